dlfloat_dot_ctrl: RTL and testbench

//  Sequencer for the DLFloat16 MAC datapath (multiplier reg -> adder -> accumulator reg). Accepts a vector

---
 rtl/dlf_pkg.sv | 18 +
 rtl/dlfloat_dot_ctrl_if.sv | 32 +++
 rtl/dlf_lat_counter.sv | 28 ++
 rtl/dlfloat_dot_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dlfloat_dot_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dlf_pkg.sv
// DLFloat16 shared definitions: sequencer states and special encodings.
// Used by the dot-product controller and the MAC datapath blocks.
package dlf_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } dlf_state_e;

    localparam logic [15:0] DLF_ZERO   = 16'h0000;
    localparam logic [15:0] DLF_INF    = 16'hFFFF;
    localparam logic [15:0] DLF_MAXPOS = 16'h7DFE;
    localparam logic [15:0] DLF_ONE    = 16'h3E00;

endpackage

// File: rtl/dlfloat_dot_ctrl_if.sv
// Controller bus: command, operand stream, MAC side and result port.
// slave = controller side, master = loader/MAC/consumer side.
interface dlfloat_dot_ctrl_if #(parameter int LEN_W = 8);

    logic             start;
    logic             abort;
    logic [LEN_W-1:0] vec_len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             acc_clr;
    logic [15:0]      mac_c;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             busy;
    logic [1:0]       exc;

    modport slave (
        input  start, abort, vec_len, in_valid, in_a, in_b, mac_c, res_ready,
        output in_ready, mac_a, mac_b, acc_clr, res_valid, res_data, busy, exc
    );

    modport master (
        output start, abort, vec_len, in_valid, in_a, in_b, mac_c, res_ready,
        input  in_ready, mac_a, mac_b, acc_clr, res_valid, res_data, busy, exc
    );

endinterface

// File: rtl/dlf_lat_counter.sv
// Loadable down-counter with zero flag; times the CLEAR and DRAIN phases.
// Saturates at zero so a held decrement is harmless.
module dlf_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // load wins over decrement; stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dlfloat_dot_ctrl.sv
// DLFloat16 dot-product sequencer: clear accumulator, issue operand pairs,
// drain the MAC pipeline and hold the captured result until taken.
// Optional DLF_EXC_FLAG_EN: sticky {inf_seen, sat_seen} flags on mac_c.
module dlfloat_dot_ctrl
    import dlf_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    dlfloat_dot_ctrl_if.slave   bus
);

    localparam int LAT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    dlf_state_e       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_in_ready;
    logic [15:0]      r_mac_a;
    logic [15:0]      r_mac_b;
    logic             r_acc_clr;
    logic             r_res_valid;
    logic [15:0]      r_res_data;
    logic             r_busy;

    logic             w_accept;
    logic             w_last;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_clr_entry;
    logic             w_lat_load;
    logic [LAT_W-1:0] w_lat_val;
    logic             w_lat_dec;
    logic             w_lat_zero;

    // abort outranks every handshake in the same cycle
    assign w_accept    = bus.in_valid && r_in_ready && !bus.abort;
    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_last      = (w_cnt_nxt == r_len);
    assign w_clr_entry = (r_state == IDLE) && bus.start && !bus.abort
                         && (bus.vec_len != '0);

    // CLEAR lasts PIPE_LAT cycles; DRAIN one more so the capture sees the
    // accumulator after the last issued product has landed
    always_comb begin
        w_lat_load = 1'b0;
        w_lat_val  = '0;
        if (w_clr_entry) begin
            w_lat_load = 1'b1;
            w_lat_val  = LAT_W'(PIPE_LAT - 1);
        end else if ((r_state == RUN) && w_accept && w_last) begin
            w_lat_load = 1'b1;
            w_lat_val  = LAT_W'(PIPE_LAT);
        end
    end

    assign w_lat_dec = (r_state == CLEAR) || (r_state == DRAIN);

    dlf_lat_counter #(.W(LAT_W)) u_lat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_lat_load),
        .i_val  (w_lat_val),
        .i_dec  (w_lat_dec),
        .o_zero (w_lat_zero)
    );

    // sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_mac_a     <= DLF_ZERO;
            r_mac_b     <= DLF_ZERO;
            r_acc_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= DLF_ZERO;
            r_busy      <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_mac_a     <= DLF_ZERO;
            r_mac_b     <= DLF_ZERO;
            r_acc_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // zero operands are a no-op contribution to the sum
            r_mac_a <= DLF_ZERO;
            r_mac_b <= DLF_ZERO;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.vec_len != '0) begin
                            r_state   <= CLEAR;
                            r_len     <= bus.vec_len;
                            r_acc_clr <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_res_data  <= DLF_ZERO;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (w_lat_zero) begin
                        r_state    <= RUN;
                        r_acc_clr  <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_mac_a <= bus.in_a;
                        r_mac_b <= bus.in_b;
                        r_cnt   <= w_cnt_nxt;
                        if (w_last) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_lat_zero) begin
                        r_state     <= DONE;
                        r_res_data  <= bus.mac_c;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.acc_clr   = r_acc_clr;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.busy      = r_busy;

`ifdef DLF_EXC_FLAG_EN
    logic [1:0] r_exc;

    // sticky exception flags, cleared when a new CLEAR phase begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_exc <= 2'b00;
        else if (w_clr_entry)
            r_exc <= 2'b00;
        else if ((r_state == RUN) || (r_state == DRAIN)) begin
            if (bus.mac_c == DLF_INF)
                r_exc[1] <= 1'b1;
            if (bus.mac_c == DLF_MAXPOS)
                r_exc[0] <= 1'b1;
        end
    end

    assign bus.exc = r_exc;
`else
    assign bus.exc = 2'b00;
`endif

endmodule

// File: tb/tb_dlfloat_dot_ctrl.sv
// Directed bench for dlfloat_dot_ctrl with a behavioural DLFloat16 MAC
// (multiplier reg -> adder -> accumulator reg) closing the loop on mac_c.
module tb_dlfloat_dot_ctrl;
    import dlf_pkg::*;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlfloat_dot_ctrl_if #(.LEN_W(LEN_W)) dif ();

    dlfloat_dot_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_acc, n_done, cyc;
    logic saw_clr, saw_rdy;
    logic [1:0] exc_at_start;

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:0] == 15'h7FFF);
    endfunction

    function automatic real dlf2r(input logic [15:0] x);
        real m;
        int  e;
        if (x[14:0] == 15'h0) return 0.0;
        e = int'(x[14:9]) - 31;
        m = 1.0 + real'(int'(x[8:0])) / 512.0;
        if (e >= 0) for (int i = 0; i < e; i++) m = m * 2.0;
        else        for (int i = 0; i < -e; i++) m = m / 2.0;
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2dlf(input real v);
        real  a;
        int   e, m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 31;
        while (a >= 2.0 && e < 70) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -10) begin a = a * 2.0; e--; end
        if (e <= 0) return 16'h0000;
        m = int'($floor((a - 1.0) * 512.0));
        if (m > 511) m = 511;
        if (e > 62 || (e == 62 && m > 510)) return s ? 16'hFDFE : 16'h7DFE;
        return {s, 6'(e), 9'(m)};
    endfunction

    function automatic logic [15:0] dlf_mul(input logic [15:0] a, input logic [15:0] b);
        if (is_inf(a) || is_inf(b)) return 16'hFFFF;
        return r2dlf(dlf2r(a) * dlf2r(b));
    endfunction

    function automatic logic [15:0] dlf_add(input logic [15:0] a, input logic [15:0] b);
        if (is_inf(a) || is_inf(b)) return 16'hFFFF;
        return r2dlf(dlf2r(a) + dlf2r(b));
    endfunction

    // MAC datapath model: two register stages, both cleared by acc_clr
    logic [15:0] m_mul, m_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mul <= 16'h0;
            m_acc <= 16'h0;
        end else if (dif.acc_clr) begin
            m_mul <= 16'h0;
            m_acc <= 16'h0;
        end else begin
            m_mul <= dlf_mul(dif.mac_a, dif.mac_b);
            m_acc <= dlf_add(m_acc, m_mul);
        end
    end
    assign dif.mac_c = m_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; tallies handshakes and observes outputs just after the edge
    task automatic step();
        logic a, d;
        a = dif.in_valid && dif.in_ready && !dif.abort;
        d = dif.res_valid && dif.res_ready && !dif.abort;
        @(posedge clk);
        #1;
        if (a) n_acc++;
        if (d) n_done++;
        if (dif.acc_clr)  saw_clr = 1'b1;
        if (dif.in_ready) saw_rdy = 1'b1;
        cyc++;
    endtask

    // start a vector of len identical pairs with gap idle cycles between pairs
    task automatic run_vec(input int len, input logic [15:0] a, input logic [15:0] b,
                           input int gap, output int lat);
        int g, k;
        n_acc = 0; saw_clr = 0; saw_rdy = 0;
        dif.vec_len  = LEN_W'(len);
        dif.in_a     = a;
        dif.in_b     = b;
        dif.in_valid = (len > 0);
        dif.start    = 1'b1;
        step();
        dif.start    = 1'b0;
        exc_at_start = dif.exc;
        cyc = 0;
        g   = 0;
        while (!dif.res_valid && cyc < 200) begin
            dif.in_valid = (n_acc < len) && (g == 0);
            k = n_acc;
            step();
            if (n_acc != k) g = gap;
            else if (g > 0) g--;
        end
        dif.in_valid = 1'b0;
        lat = cyc;
        chk("res_valid_timeout", dif.res_valid, 1);
    endtask

    task automatic take(input string tag);
        dif.res_ready = 1'b1;
        step();
        dif.res_ready = 1'b0;
        chk({tag, "_rv_low"}, dif.res_valid, 0);
        chk({tag, "_idle"},   dif.busy, 0);
    endtask

    initial begin
        int lat, d0;
        logic [1:0] exc_exp;
        dif.start = 0; dif.abort = 0; dif.vec_len = '0; dif.in_valid = 0;
        dif.in_a = 0; dif.in_b = 0; dif.res_ready = 0;
        n_acc = 0; n_done = 0; cyc = 0; saw_clr = 0; saw_rdy = 0; exc_at_start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  dif.in_ready, 0);
        chk("rst_mac_a",     dif.mac_a, 0);
        chk("rst_mac_b",     dif.mac_b, 0);
        chk("rst_acc_clr",   dif.acc_clr, 0);
        chk("rst_res_valid", dif.res_valid, 0);
        chk("rst_res_data",  dif.res_data, 0);
        chk("rst_busy",      dif.busy, 0);
        chk("rst_exc",       dif.exc, 0);
        rst_n = 1'b1;
        step();

        // 3 x (1.0 * 2.0) back to back = 6.0
        n_done = 0;
        run_vec(3, 16'h3E00, 16'h4000, 0, lat);
        chk("b2b_latency", lat, 8);
        chk("b2b_data",    dif.res_data, 16'h4300);
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_exc",     dif.exc, 0);
        take("b2b");
        chk("b2b_completions", n_done, 1);

        // same vector with two bubble cycles between pairs
        run_vec(3, 16'h3E00, 16'h4000, 2, lat);
        chk("gap_latency", lat, 12);
        chk("gap_data",    dif.res_data, 16'h4300);
        chk("gap_accepts", n_acc, 3);
        take("gap");

        // zero length: immediate result, no clear, no operand window
        run_vec(0, 16'h3E00, 16'h3E00, 0, lat);
        chk("len0_latency",  lat, 0);
        chk("len0_data",     dif.res_data, 16'h0000);
        chk("len0_no_clr",   saw_clr, 0);
        chk("len0_no_ready", saw_rdy, 0);
        chk("len0_busy",     dif.busy, 1);
        take("len0");

        // abort in RUN after the first of four pairs, with in_valid still high
        n_acc = 0; cyc = 0;
        dif.vec_len = LEN_W'(4); dif.in_a = 16'h3E00; dif.in_b = 16'h4000;
        dif.in_valid = 1'b1; dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        while (n_acc < 1 && cyc < 20) step();
        chk("abort_first_accept", n_acc, 1);
        dif.abort = 1'b1;
        step();
        dif.abort = 1'b0; dif.in_valid = 1'b0;
        chk("abort_accepts",  n_acc, 1);
        chk("abort_busy",     dif.busy, 0);
        chk("abort_in_ready", dif.in_ready, 0);
        chk("abort_mac_a",    dif.mac_a, 0);
        chk("abort_rv",       dif.res_valid, 0);
        run_vec(1, 16'h3E00, 16'h3E00, 0, lat);
        chk("post_abort_latency", lat, 6);
        chk("post_abort_data",    dif.res_data, 16'h3E00);
        take("post_abort");

        // stall in DONE with start pulses: result holds, one completion only
        run_vec(2, 16'h3E00, 16'h4000, 0, lat);
        chk("stall_data", dif.res_data, 16'h4200);
        n_done = 0;
        d0 = 0;
        dif.vec_len = LEN_W'(5);
        for (int i = 0; i < 5; i++) begin
            dif.start = (i % 2 == 0);
            step();
            if (dif.res_valid !== 1'b1 || dif.res_data !== 16'h4200 || dif.acc_clr !== 1'b0) d0++;
        end
        dif.start = 1'b0;
        chk("stall_hold_errors", d0, 0);
        chk("stall_no_completion", n_done, 0);
        take("stall");
        step();
        chk("stall_completions", n_done, 1);
        chk("stall_stays_idle",  dif.busy, 0);

        // infinity through the MAC raises the sticky flag when enabled
`ifdef DLF_EXC_FLAG_EN
        exc_exp = 2'b10;
`else
        exc_exp = 2'b00;
`endif
        run_vec(1, 16'hFFFF, 16'h3E00, 0, lat);
        chk("inf_data", dif.res_data, 16'hFFFF);
        chk("inf_exc",  dif.exc, exc_exp);
        take("inf");
        run_vec(1, 16'h3E00, 16'h3E00, 0, lat);
        chk("exc_cleared_at_clear", exc_at_start, 0);
        chk("exc_after_clean_run",  dif.exc, 0);
        chk("clean_data",           dif.res_data, 16'h3E00);
        take("clean");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
